// File: rtl/vector_scan_seq.sv
// ----------------------------------------------------------------------------
// vector_scan_seq
//
// Sequential first-match scanner. A DATA_W-bit vector is accepted over a
// valid/ready handshake and examined SEG_W bits per clock. The scan stops on
// the first segment that holds a match and reports the position of the match.
// If no bit matches, it reports DATA_W with found_out=0.
//
// mode_in[0] : 0 = look for the first 1, 1 = look for the first 0
// mode_in[1] : 0 = scan from the MSB (pos = number of non-matching bits above
//                  the match), 1 = scan from the LSB (pos = bit index)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   data_in / mode_in valid
//   in_ready   out  high only while idle
//   data_in    in   DATA_W vector to scan
//   mode_in    in   target value and scan direction
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts the result
//   pos_out    out  POS_W position of the first match (DATA_W if none)
//   found_out  out  1 if a match exists
// ----------------------------------------------------------------------------
module vector_scan_seq #(
    parameter int DATA_W = 64,
    parameter int SEG_W  = 8,
    localparam int POS_W = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  pos_out,
    output logic              found_out
);

    localparam int NSEG      = DATA_W / SEG_W;
    localparam int SEG_IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int SEG_POS_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // Fold the mode into the vector at acceptance: after this, a match is
    // always a 1 and bit i is the i-th bit counted from the scan origin. Both
    // scan directions then share one encoder and pos = s*SEG_W + k holds for
    // either direction.
    function automatic logic [DATA_W-1:0] orient(input logic [DATA_W-1:0] d,
                                                 input logic [1:0]        m);
        logic [DATA_W-1:0] norm;
        logic [DATA_W-1:0] rev;
        norm = d ^ {DATA_W{m[0]}};
        for (int i = 0; i < DATA_W; i++) begin
            rev[i] = norm[DATA_W-1-i];
        end
        return m[1] ? norm : rev;
    endfunction

    // Lowest set bit of a segment (lowest = nearest the scan origin).
    // Returns {hit, index}.
    function automatic logic [SEG_POS_W:0] first_one(input logic [SEG_W-1:0] seg);
        logic                 hit;
        logic [SEG_POS_W-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int k = SEG_W - 1; k >= 0; k--) begin
            if (seg[k]) begin
                hit = 1'b1;
                idx = SEG_POS_W'(k);
            end
        end
        return {hit, idx};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                state_q,   state_d;
    logic [DATA_W-1:0]     vec_q,     vec_d;
    logic [SEG_IDX_W-1:0]  seg_idx_q, seg_idx_d;
    logic [POS_W-1:0]      pos_q,     pos_d;
    logic                  found_q,   found_d;

    // ------------------------------------------------------------------------
    // Segment evaluation
    // ------------------------------------------------------------------------
    logic [POS_W-1:0]     seg_base;
    logic [SEG_W-1:0]     seg_bits;
    logic [SEG_POS_W:0]   enc;
    logic                 seg_hit;
    logic [SEG_POS_W-1:0] seg_off;
    logic [POS_W-1:0]     match_pos;
    logic                 last_seg;
    logic                 accept;

    always_comb begin
        seg_base  = POS_W'(seg_idx_q) * POS_W'(SEG_W);
        seg_bits  = SEG_W'(vec_q >> seg_base);
        enc       = first_one(seg_bits);
        seg_hit   = enc[SEG_POS_W];
        seg_off   = enc[SEG_POS_W-1:0];
        match_pos = seg_base + POS_W'(seg_off);
        last_seg  = (seg_idx_q == SEG_IDX_W'(NSEG - 1));
        accept    = in_valid && (state_q == S_IDLE);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            seg_idx_q <= '0;
            pos_q     <= '0;
            found_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            seg_idx_q <= seg_idx_d;
            pos_q     <= pos_d;
            found_q   <= found_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)            state_d = S_SCAN;
            S_SCAN: if (seg_hit || last_seg) state_d = S_DONE;
            S_DONE: if (out_ready)           state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        vec_d     = vec_q;
        seg_idx_d = seg_idx_q;
        pos_d     = pos_q;
        found_d   = found_q;
        if (accept) begin
            // Data and mode are captured once here; later changes on the
            // inputs cannot affect the running scan.
            vec_d     = orient(data_in, mode_in);
            seg_idx_d = '0;
        end else if (state_q == S_SCAN) begin
            if (seg_hit) begin
                pos_d   = match_pos;
                found_d = 1'b1;
            end else if (last_seg) begin
                pos_d   = POS_W'(DATA_W);
                found_d = 1'b0;
            end else begin
                seg_idx_d = seg_idx_q + SEG_IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from the registered state so reset clears them at once)
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        pos_out   = pos_q;
        found_out = found_q;
    end

endmodule

// File: tb/tb_vector_scan_seq.sv
module tb_vector_scan_seq;

    localparam int DATA_W = 64;
    localparam int SEG_W  = 8;
    localparam int NSEG   = DATA_W / SEG_W;
    localparam int POS_W  = $clog2(DATA_W) + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        mode_in;
    logic              out_valid;
    logic              out_ready;
    logic [POS_W-1:0]  pos_out;
    logic              found_out;

    vector_scan_seq #(.DATA_W(DATA_W), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pos_out   (pos_out),
        .found_out (found_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [POS_W-1:0] pos;
        logic             found;
        int               lat;
        time              acc_t;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic rnd_bp   = 1'b0;
    logic or_force = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: walk the bits outward from the scan origin and stop at the
    // first one equal to the target value.
    function automatic void model(input logic [63:0] d, input logic [1:0] m,
                                  output logic [POS_W-1:0] pos, output logic f,
                                  output int lat);
        pos = POS_W'(DATA_W);
        f   = 1'b0;
        lat = NSEG;
        for (int c = 0; c < DATA_W; c++) begin
            bit b;
            b = m[1] ? d[c] : d[DATA_W-1-c];
            if (!f && (b == !m[0])) begin
                f   = 1'b1;
                pos = POS_W'(c);
                lat = c / SEG_W + 1;
            end
        end
    endfunction

    // out_ready changes shortly after each rising edge, well clear of sampling.
    always @(posedge clk) begin
        #2;
        out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : or_force;
    end

    // Monitor / scoreboard
    logic             seen    = 1'b0;
    logic             hold_v  = 1'b0;
    logic             prev_hs = 1'b0;
    logic [POS_W-1:0] hold_pos;
    logic             hold_found;
    exp_t             em;

    always @(negedge clk) begin
        if (rst) begin
            seen    = 1'b0;
            hold_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                chk("idle_after_handshake_in_ready", 64'(in_ready), 1);
                chk("idle_after_handshake_out_valid", 64'(out_valid), 0);
            end
            if (hold_v) begin
                chk("backpressure_valid_held", 64'(out_valid), 1);
                if (out_valid) begin
                    chk("backpressure_pos_stable", 64'(pos_out), 64'(hold_pos));
                    chk("backpressure_found_stable", 64'(found_out), 64'(hold_found));
                end
            end
            if (out_valid) begin
                chk("in_ready_low_while_valid", 64'(in_ready), 0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual pos=%0d required no output", pos_out);
                    end else begin
                        em = sb.pop_front();
                        chk("pos_out", 64'(pos_out), 64'(em.pos));
                        chk("found_out", 64'(found_out), 64'(em.found));
                        chk("latency", 64'(int'(($time - em.acc_t - 5) / 10)), 64'(em.lat));
                    end
                    seen = 1'b1;
                end
            end
            hold_v     = out_valid && !out_ready;
            hold_pos   = pos_out;
            hold_found = found_out;
            prev_hs    = out_valid && out_ready;
            if (prev_hs) seen = 1'b0;
        end
    end

    task automatic send(input logic [63:0] d, input logic [1:0] m);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_wait_in_ready", 64'(in_ready), 1);
            return;
        end
        in_valid = 1'b1;
        data_in  = d;
        mode_in  = m;
        @(posedge clk);
        e.acc_t = $time;
        model(d, m, e.pos, e.found, e.lat);
        sb.push_back(e);
        #1;
        // Scramble the inputs after acceptance; the result must not move.
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom};
        mode_in  = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_complete", 64'(sb.size() == 0 && in_ready), 1);
    endtask

    function automatic logic [63:0] rand_vec();
        logic [63:0] one;
        one = 64'd1 << $urandom_range(0, 63);
        case ($urandom_range(0, 5))
            0:       return {$urandom, $urandom};
            1:       return one;
            2:       return '1;
            3:       return '0;
            4:       return ~one;
            default: return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] dvec [6];
        logic [1:0]  dmode[6];
        dvec[0] = 64'h0;                   dmode[0] = 2'b00;
        dvec[1] = 64'h8000_0000_0000_0000; dmode[1] = 2'b00;
        dvec[2] = 64'h0000_0000_0010_0000; dmode[2] = 2'b00;
        dvec[3] = 64'h0000_0000_0010_0000; dmode[3] = 2'b10;
        dvec[4] = 64'hFFFF_FFFF_FFFF_FFFE; dmode[4] = 2'b01;
        dvec[5] = 64'hFFFF_FFFF_FFFF_FFFF; dmode[5] = 2'b11;

        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        mode_in   = 2'b00;
        out_ready = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 1);
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_pos_out", 64'(pos_out), 0);
        chk("reset_found_out", 64'(found_out), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            send(dvec[i], dmode[i]);
            drain();
        end

        // Backpressure with ignored input pulses
        or_force = 1'b0;
        send(64'h0000_0001_0000_0000, 2'b00);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 1);
            chk("bp_in_ready", 64'(in_ready), 0);
            chk("bp_pos_out", 64'(pos_out), 31);
            in_valid = 1'(k % 2 == 0);
            data_in  = {$urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        or_force = 1'b1;
        drain();
        send(64'h8000_0000_0000_0000, 2'b00);
        drain();

        // Reset in the middle of a scan
        send(64'h0, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midscan_reset_out_valid", 64'(out_valid), 0);
        chk("midscan_reset_in_ready", 64'(in_ready), 1);
        chk("midscan_reset_pos_out", 64'(pos_out), 0);
        chk("midscan_reset_found_out", 64'(found_out), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(64'h1, 2'b00);
        drain();

        // Randomised traffic with random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(rand_vec(), 2'($urandom_range(0, 3)));
        end
        drain();
        rnd_bp = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
